// File: rtl/amp_seq_ctrl.sv
// Amplifier power sequencer: enable, settle, push a register table over I2C, unmute;
// reverse order on disable. FAULT on NACK, cleared by dropping amp_on.
module amp_seq_ctrl #(
  parameter logic [6:0]  DEV_ADDR  = 7'h2C,
  parameter int unsigned EN_WAIT   = 1200,
  parameter int unsigned MUTE_WAIT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        amp_on,
  input  logic [3:0]  tbl_len,
  output logic [3:0]  tbl_idx,
  input  logic [15:0] tbl_entry,
  output logic        wr_req,
  output logic [6:0]  wr_dev,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        amp_nenable,
  output logic        amp_mute,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state_mon
);

  localparam int unsigned MAXW = (EN_WAIT > MUTE_WAIT) ? EN_WAIT : MUTE_WAIT;
  localparam int unsigned CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] EN_LOAD   = CW'(EN_WAIT - 1);
  localparam logic [CW-1:0] MUTE_LOAD = CW'(MUTE_WAIT - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWRUP     = 3'd1,
    S_CFG_ISSUE = 3'd2,
    S_CFG_WAIT  = 3'd3,
    S_UNMUTE    = 3'd4,
    S_RUN       = 3'd5,
    S_MUTE      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [3:0]    idx_n, idx_inc;
  logic          req_n, nen_n, mute_n, busy_n, fault_n;
  logic [7:0]    reg_n, data_n;

  assign wr_dev    = DEV_ADDR;
  assign state_mon = state;
  assign idx_inc   = tbl_idx + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_OFF;
      count       <= '0;
      tbl_idx     <= '0;
      wr_req      <= 1'b0;
      wr_reg      <= '0;
      wr_data     <= '0;
      amp_nenable <= 1'b1;
      amp_mute    <= 1'b1;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      tbl_idx     <= idx_n;
      wr_req      <= req_n;
      wr_reg      <= reg_n;
      wr_data     <= data_n;
      amp_nenable <= nen_n;
      amp_mute    <= mute_n;
      busy        <= busy_n;
      fault       <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    idx_n   = tbl_idx;
    req_n   = wr_req;
    reg_n   = wr_reg;
    data_n  = wr_data;
    nen_n   = amp_nenable;
    mute_n  = amp_mute;

    case (state)
      S_OFF: begin
        nen_n  = 1'b1;
        mute_n = 1'b1;
        req_n  = 1'b0;
        if (amp_on) begin
          state_n = S_PWRUP;
          nen_n   = 1'b0;
          count_n = EN_LOAD;
        end
      end
      S_PWRUP: begin
        if (!amp_on) begin
          state_n = S_MUTE;
          mute_n  = 1'b1;
          count_n = MUTE_LOAD;
        end else if (count == '0) begin
          if (tbl_len == '0) begin
            state_n = S_UNMUTE;
            count_n = MUTE_LOAD;
          end else begin
            idx_n   = '0;
            state_n = S_CFG_ISSUE;
          end
        end else begin
          count_n = count - 1'b1;
        end
      end
      S_CFG_ISSUE: begin
        if (!amp_on) begin
          state_n = S_MUTE;
          mute_n  = 1'b1;
          count_n = MUTE_LOAD;
        end else begin
          reg_n   = tbl_entry[15:8];
          data_n  = tbl_entry[7:0];
          req_n   = 1'b1;
          state_n = S_CFG_WAIT;
        end
      end
      S_CFG_WAIT: begin
        // An in-flight write always completes; amp_on is only honoured at wr_done.
        if (wr_done) begin
          req_n = 1'b0;
          if (wr_nack) begin
            state_n = S_FAULT;
            nen_n   = 1'b1;
            mute_n  = 1'b1;
          end else begin
            idx_n = idx_inc;
            if (!amp_on) begin
              state_n = S_MUTE;
              count_n = MUTE_LOAD;
            end else if (idx_inc == tbl_len) begin
              state_n = S_UNMUTE;
              count_n = MUTE_LOAD;
            end else begin
              state_n = S_CFG_ISSUE;
            end
          end
        end
      end
      S_UNMUTE: begin
        if (!amp_on) begin
          state_n = S_MUTE;
          mute_n  = 1'b1;
          count_n = MUTE_LOAD;
        end else if (count == '0) begin
          mute_n  = 1'b0;
          state_n = S_RUN;
        end else begin
          count_n = count - 1'b1;
        end
      end
      S_RUN: begin
        if (!amp_on) begin
          mute_n  = 1'b1;
          count_n = MUTE_LOAD;
          state_n = S_MUTE;
        end
      end
      S_MUTE: begin
        mute_n = 1'b1;
        if (count == '0) begin
          nen_n   = 1'b1;
          state_n = S_OFF;
        end else begin
          count_n = count - 1'b1;
        end
      end
      S_FAULT: begin
        nen_n  = 1'b1;
        mute_n = 1'b1;
        req_n  = 1'b0;
        if (!amp_on) state_n = S_OFF;
      end
      default: state_n = S_OFF;
    endcase

    busy_n  = !(state_n == S_OFF || state_n == S_RUN || state_n == S_FAULT);
    fault_n = (state_n == S_FAULT);
  end

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Bench for amp_seq_ctrl: I2C responder model, write scoreboard, directed sequencing scenarios.
module tb_amp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        amp_on;
  logic [3:0]  tbl_len;
  logic [3:0]  tbl_idx;
  logic [15:0] tbl_entry;
  logic        wr_req;
  logic [6:0]  wr_dev;
  logic [7:0]  wr_reg;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        wr_nack;
  logic        amp_nenable;
  logic        amp_mute;
  logic        busy;
  logic        fault;
  logic [2:0]  state_mon;

  localparam logic [2:0] ST_OFF = 3'd0, ST_PWRUP = 3'd1, ST_WAIT = 3'd3,
                         ST_RUN = 3'd5, ST_MUTE = 3'd6, ST_FAULT = 3'd7;

  logic [15:0] tbl [16];
  logic [15:0] exp_q [$];
  int checks = 0, errors = 0;
  int cyc = 0, nwrites = 0, resp_n = 0, nack_at = 0, last_ack = 0;
  int n, m, base;
  logic spurious = 1'b0;
  logic req_q = 1'b0;

  amp_seq_ctrl #(.DEV_ADDR(7'h2C), .EN_WAIT(8), .MUTE_WAIT(4)) dut (
    .clk(clk), .reset(rst), .amp_on(amp_on), .tbl_len(tbl_len), .tbl_idx(tbl_idx),
    .tbl_entry(tbl_entry), .wr_req(wr_req), .wr_dev(wr_dev), .wr_reg(wr_reg),
    .wr_data(wr_data), .wr_done(wr_done), .wr_nack(wr_nack), .amp_nenable(amp_nenable),
    .amp_mute(amp_mute), .busy(busy), .fault(fault), .state_mon(state_mon)
  );

  always #5 clk = ~clk;
  always_comb tbl_entry = tbl[tbl_idx];
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {amp_nenable, amp_mute, wr_req, wr_reg, wr_data, tbl_idx, busy, fault, state_mon},
        {2'b11, 26'd0});
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int i = 0;
    do begin @(negedge clk); i++; end while (state_mon !== s && i < limit);
    chk(name, state_mon, s);
  endtask

  task automatic push_table3();
    exp_q.push_back(16'h01A5);
    exp_q.push_back(16'h0233);
    exp_q.push_back(16'h0380);
  endtask

  // I2C master model: ack 5 cycles after wr_req rises, optional NACK on a chosen write
  initial begin
    int cnt = 0;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (wr_req) cnt++; else cnt = 0;
      if (cnt == 5) begin
        resp_n++;
        wr_done  = 1'b1;
        wr_nack  = (resp_n == nack_at);
        last_ack = cyc + 1;
      end else if (spurious) begin
        wr_done  = 1'b1;
        spurious = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every rising wr_req must match the next expected table write
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (wr_req && !req_q) begin
        nwrites++;
        if (exp_q.size() == 0) chk("unexpected_write", {wr_reg, wr_data}, 16'hxxxx);
        else chk("write", {wr_dev, wr_reg, wr_data}, {7'h2C, exp_q.pop_front()});
      end
      chk("en_mute_both_low_outside_run",
          (!amp_nenable && !amp_mute && state_mon != ST_RUN), 1'b0);
    end
    req_q = wr_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = 16'h01A5; tbl[1] = 16'h0233; tbl[2] = 16'h0380;
    for (int i = 3; i < 16; i++) tbl[i] = 16'hEE00 | 16'(i);
    rst = 1'b1; amp_on = 1'b0; tbl_len = 4'd3;
    repeat (2) @(negedge clk);
    chk_reset("reset_values");
    rst = 1'b0;
    @(negedge clk);

    // Three-entry table power-up
    push_table3();
    amp_on = 1'b1; n = cyc + 1;
    @(negedge clk);
    chk("nen_low_after_req", {amp_nenable, state_mon, busy}, {1'b0, ST_PWRUP, 1'b1});
    chk("nen_fall_edge", cyc, n);
    wait_state(ST_RUN, 200, "reach_run_tbl3");
    chk("mute_fall_after_last_ack", cyc, last_ack + 4);
    chk("run_outputs", {amp_mute, amp_nenable, busy, fault}, 4'b0000);
    chk("writes_tbl3", nwrites, 3);

    // Power down, then empty table
    amp_on = 1'b0;
    wait_state(ST_OFF, 50, "off_after_run");
    tbl_len = 4'd0;
    amp_on = 1'b1; n = cyc + 1;
    @(negedge clk);
    chk("nen_fall_tbl0", {amp_nenable, cyc}, {1'b0, n});
    wait_state(ST_RUN, 100, "reach_run_tbl0");
    chk("mute_fall_tbl0", cyc, n + 12);
    chk("no_writes_tbl0", nwrites, 3);

    // Spurious wr_done in RUN, then RUN power-down timing, then spurious in OFF
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_run", {state_mon, wr_req, amp_mute}, {ST_RUN, 2'b00});
    amp_on = 1'b0; m = cyc + 1;
    @(negedge clk);
    chk("mute_after_off_req", {amp_mute, amp_nenable, state_mon}, {2'b10, ST_MUTE});
    wait_state(ST_OFF, 50, "off_after_mute");
    chk("nen_rise_time", {amp_nenable, cyc}, {1'b1, m + 4});
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_off", {state_mon, amp_nenable, amp_mute, 32'(nwrites)}, {ST_OFF, 2'b11, 32'd3});

    // NACK on the second write
    tbl_len = 4'd3;
    nack_at = resp_n + 2;
    exp_q.push_back(16'h01A5);
    exp_q.push_back(16'h0233);
    amp_on = 1'b1;
    wait_state(ST_FAULT, 200, "enter_fault");
    chk("fault_outputs", {wr_req, fault, amp_nenable, amp_mute, busy}, 5'b01110);
    repeat (10) @(negedge clk);
    chk("fault_hold_no_third", {fault, state_mon, 32'(nwrites)}, {1'b1, ST_FAULT, 32'd5});
    amp_on = 1'b0;
    @(negedge clk);
    chk("fault_clear", {state_mon, fault}, {ST_OFF, 1'b0});
    nack_at = 0;
    push_table3();
    amp_on = 1'b1;
    wait_state(ST_RUN, 200, "restart_after_fault");
    chk("writes_after_restart", nwrites, 8);

    // Drop amp_on while a write is pending
    amp_on = 1'b0;
    wait_state(ST_OFF, 50, "off_before_abort");
    exp_q.push_back(16'h01A5);
    amp_on = 1'b1;
    wait_state(ST_WAIT, 100, "enter_cfg_wait");
    amp_on = 1'b0;
    @(negedge clk);
    chk("req_held_on_abort", {wr_req, state_mon, wr_reg, wr_data}, {1'b1, ST_WAIT, 16'h01A5});
    wait_state(ST_MUTE, 50, "mute_after_abort_ack");
    chk("abort_mute_at_ack", {wr_req, cyc}, {1'b0, last_ack});
    wait_state(ST_OFF, 50, "off_after_abort");
    chk("abort_off_time", {amp_nenable, cyc}, {1'b1, last_ack + 4});
    repeat (10) @(negedge clk);
    chk("no_writes_after_abort", nwrites, 9);

    // Async reset mid-PWRUP and mid-CFG_WAIT
    amp_on = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("reset_mid_pwrup");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_pwrup_1", {state_mon, amp_nenable}, {ST_PWRUP, 1'b0});
    exp_q.push_back(16'h01A5);
    wait_state(ST_WAIT, 100, "cfg_wait_before_reset");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("reset_mid_cfg_wait");
    @(negedge clk);
    rst = 1'b0;
    base = nwrites;
    push_table3();
    @(negedge clk);
    chk("restart_pwrup_2", {state_mon, amp_nenable}, {ST_PWRUP, 1'b0});
    wait_state(ST_RUN, 200, "run_after_reset");
    chk("writes_after_reset", nwrites, base + 3);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
